pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture_pkg.sv | 31 +++
 rtl/pwm_capture_div.sv | 83 ++++++++
 rtl/pwm_capture.sv | 223 ++++++++++++++++++++++
 tb/tb_pwm_capture.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// rtl/pwm_capture_pkg.sv - shared types and constants for the PWM capture block
//
// Holds the measurement FSM state type, the default counter width and the
// LED bar thresholds, plus the helper that maps a duty value onto the bar.

package pwm_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DIVIDE  = 2'd2
  } state_t;

  localparam int CNT_W_DEFAULT = 24;

  // Bar LED i lights once duty reaches BAR_STEP*(i+1); the top LED only at full scale.
  localparam int         BAR_STEP  = 32;
  localparam int         BAR_STEPS = 7;
  localparam logic [7:0] DUTY_FULL = 8'hFF;

  function automatic logic [7:0] bar_of(input logic [7:0] duty);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < BAR_STEPS; i++) begin
      b[i] = (int'(duty) >= BAR_STEP * (i + 1));
    end
    b[7] = (duty == DUTY_FULL);
    return b;
  endfunction

endpackage

// File: rtl/pwm_capture_div.sv
// rtl/pwm_capture_div.sv - 8-bit-quotient sequential restoring divider
//
// Computes floor(dividend*256/divisor), clamped to 255 when dividend >= divisor.
// The first quotient bit is resolved in the start cycle itself, so the last
// of the eight bits lands one cycle before done is seen by the caller.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle request; operands sampled in the same cycle
//   dividend, divisor   CNT_W-bit operands (high time, period)
//   busy                division in progress
//   done                one-cycle pulse when quotient is final
//   quotient            8-bit result, held until the next start

module pwm_capture_div
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [7:0]       quotient
);

  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] dvs;
  logic [7:0]       q;
  logic [2:0]       step_cnt;
  logic             clamp;

  logic [CNT_W-1:0] src_rem;
  logic [CNT_W-1:0] src_dvs;
  logic [CNT_W:0]   shifted;
  logic             take;
  logic [CNT_W-1:0] rem_next;

  // One restoring step; on start it works straight from the operand inputs.
  always_comb begin
    src_rem  = start ? dividend : rem;
    src_dvs  = start ? divisor : dvs;
    shifted  = {src_rem, 1'b0};
    take     = (shifted >= {1'b0, src_dvs});
    rem_next = take ? (shifted[CNT_W-1:0] - src_dvs) : shifted[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      dvs      <= '0;
      q        <= '0;
      step_cnt <= '0;
      clamp    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem      <= rem_next;
        dvs      <= divisor;
        q        <= {7'd0, take};
        clamp    <= (dividend >= divisor);
        step_cnt <= 3'd1;
        busy     <= 1'b1;
      end else if (busy) begin
        rem      <= rem_next;
        q        <= {q[6:0], take};
        step_cnt <= step_cnt + 3'd1;
        if (step_cnt == 3'd7) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = clamp ? DUTY_FULL : q;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period / high-time / duty capture with loss-of-signal
//
// Measures an asynchronous PWM input between consecutive rising edges and
// reports period, high time, 8-bit duty and a thermometer LED bar. A divide
// takes eight cycles; the result appears nine cycles after the edge cycle.
// With no rising edge for TIMEOUT_CYCLES (2 ms at CLK_FREQ = 12 MHz) the
// block raises no_signal, reports 0 or 255 duty from the held level, and
// waits for two fresh edges.
//
// Build option: define PWM_CAPTURE_DEGLITCH_EN to add a 3-sample majority-free
// persistence filter after the synchronizer (pulses under 3 cycles vanish,
// edges arrive 2 cycles later).
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   pwm_in       external PWM, asynchronous to clk
//   duty         floor(high_time*256/period), clamped to 255
//   period       cycles between the last two rising edges
//   high_time    cycles high within that period
//   valid        one-cycle pulse when the outputs update
//   no_signal    loss-of-signal level
//   bar          thermometer of duty for the LED row

module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CLK_FREQ       = 12_000_000,
  parameter int TIMEOUT_CYCLES = 24000,
  parameter int CNT_W          = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [7:0]       duty,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             no_signal,
  output logic [7:0]       bar
);

  if (CLK_FREQ <= 0 || TIMEOUT_CYCLES <= 0) begin : g_param_check
    $error("pwm_capture: CLK_FREQ and TIMEOUT_CYCLES must be positive");
  end

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  // ---------------------------------------------------------------- input path
  logic sync_a;
  logic sync_b;
  logic level;
  logic level_q;
  logic rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= pwm_in;
      sync_b <= sync_a;
    end
  end

`ifdef PWM_CAPTURE_DEGLITCH_EN
  logic hist_a;
  logic hist_b;
  logic filt_q;

  // The filtered level follows the synchronized one only once the current and
  // two previous samples agree; evaluated combinationally so a clean edge
  // costs exactly two extra cycles.
  always_comb begin
    level = filt_q;
    if (sync_b == hist_a && sync_b == hist_b) begin
      level = sync_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_a <= 1'b0;
      hist_b <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      hist_a <= sync_b;
      hist_b <= hist_a;
      filt_q <= level;
    end
  end
`else
  assign level = sync_b;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign rise = level & ~level_q;

  // ------------------------------------------------------------------ counters
  state_t           state;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_inc;
  logic [CNT_W-1:0] high_inc;
  logic [CNT_W-1:0] lat_period;
  logic [CNT_W-1:0] lat_high;

  // Both counters saturate at the timeout so a stuck input can never wrap.
  always_comb begin
    period_inc = (period_cnt == TIMEOUT_C) ? period_cnt : period_cnt + ONE_C;
    high_inc   = high_cnt;
    if (level && high_cnt != TIMEOUT_C) begin
      high_inc = high_cnt + ONE_C;
    end
  end

  // ------------------------------------------------------------------- divider
  logic       div_start;
  logic       div_busy;
  logic       div_done;
  logic [7:0] div_q;

  // The divider samples the live counters in the edge cycle, the same values
  // the FSM latches for the period/high_time outputs.
  assign div_start = (state == ST_MEASURE) && rise;

  pwm_capture_div #(
    .CNT_W(CNT_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (high_cnt),
    .divisor  (period_cnt),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  // ----------------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      period_cnt <= '0;
      high_cnt   <= '0;
      lat_period <= '0;
      lat_high   <= '0;
      duty       <= '0;
      period     <= '0;
      high_time  <= '0;
      valid      <= 1'b0;
      no_signal  <= 1'b1;
      bar        <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise) begin
            period_cnt <= ONE_C;
            high_cnt   <= CNT_W'(level);
            state      <= ST_MEASURE;
          end
        end

        ST_MEASURE: begin
          if (rise) begin
            lat_period <= period_cnt;
            lat_high   <= high_cnt;
            period_cnt <= ONE_C;
            high_cnt   <= CNT_W'(level);
            state      <= ST_DIVIDE;
          end else if (period_cnt == TIMEOUT_C) begin
            duty       <= level ? DUTY_FULL : 8'd0;
            bar        <= bar_of(level ? DUTY_FULL : 8'd0);
            period     <= '0;
            high_time  <= '0;
            no_signal  <= 1'b1;
            valid      <= 1'b1;
            period_cnt <= '0;
            high_cnt   <= '0;
            state      <= ST_IDLE;
          end else begin
            period_cnt <= period_inc;
            high_cnt   <= high_inc;
          end
        end

        ST_DIVIDE: begin
          // An edge here restarts the counters but its period is discarded.
          if (rise) begin
            period_cnt <= ONE_C;
            high_cnt   <= CNT_W'(level);
          end else begin
            period_cnt <= period_inc;
            high_cnt   <= high_inc;
          end
          if (div_done) begin
            duty      <= div_q;
            bar       <= bar_of(div_q);
            period    <= lat_period;
            high_time <= lat_high;
            no_signal <= 1'b0;
            valid     <= 1'b1;
            state     <= ST_MEASURE;
          end else if (!div_busy) begin
            // Divider idle without a result: the measurement is lost, resync.
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - scoreboard bench for pwm_capture with edge-level reference model

module tb_pwm_capture;

  localparam int CW = 24;
  localparam int TO = 13000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pwm_in = 1'b0;
  logic [7:0]    duty;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          valid;
  logic          no_signal;
  logic [7:0]    bar;

  pwm_capture #(
    .CLK_FREQ       (12_000_000),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_in    (pwm_in),
    .duty      (duty),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .no_signal (no_signal),
    .bar       (bar)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int t;
    int p;
    int h;
    int d;
    bit ns;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;

  // Reference model state, in pin-time cycles.
  bit m_lv, m_h1, m_h2, m_armed;
  int m_last, m_hcnt, m_busy;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int duty_ref(input int h, input int p);
    if (p <= 0 || h >= p) return 255;
    return (h * 256) / p;
  endfunction

  function automatic logic [7:0] bar_ref(input int d);
    int n;
    logic [7:0] b;
    n = d / 32;
    b = 8'((1 << n) - 1) & 8'h7F;
    b[7] = (d == 255);
    return b;
  endfunction

  function automatic exp_t reset_rec();
    exp_t e;
    e.t = 0; e.p = 0; e.h = 0; e.d = 0; e.ns = 1'b1;
    return e;
  endfunction

  task automatic push_exp(input int t, input int p, input int h, input int d, input bit ns);
    exp_t e;
    e.t = t; e.p = p; e.h = h; e.d = d; e.ns = ns;
    sbq.push_back(e);
  endtask

  // Pin value b is applied in cycle c; the synchronized edge is seen at c+2,
  // a measurement result nine cycles later, a timeout one cycle later.
  task automatic model_step(input bit b, input int c);
    bit nl;
`ifdef PWM_CAPTURE_DEGLITCH_EN
    nl = (b == m_h1 && b == m_h2) ? b : m_lv;
    m_h2 = m_h1;
    m_h1 = b;
`else
    nl = b;
`endif
    if (nl && !m_lv) begin
      if (m_armed && c > m_busy) begin
        push_exp(c + 11, c - m_last, m_hcnt, duty_ref(m_hcnt, c - m_last), 1'b0);
        m_busy = c + 8;
      end
      m_armed = 1'b1;
      m_last  = c;
      m_hcnt  = 0;
    end else if (m_armed && (c - m_last) == TO) begin
      push_exp(c + 3, 0, 0, nl ? 255 : 0, 1'b1);
      m_armed = 1'b0;
    end
    m_lv = nl;
    if (m_lv) m_hcnt++;
  endtask

  task automatic model_reset();
    m_lv = 0; m_h1 = 0; m_h2 = 0; m_armed = 0;
    m_last = 0; m_hcnt = 0; m_busy = -100;
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].t > cyc) sbq.delete(i);
    end
  endtask

  task automatic drive_bit(input bit b);
    @(posedge clk);
    #1;
    pwm_in = b;
    model_step(b, cyc);
  endtask

  task automatic drive_pwm(input int p, input int h, input int n);
    repeat (n) begin
      repeat (h) drive_bit(1'b1);
      repeat (p - h) drive_bit(1'b0);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_duty"}, duty, 0);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_high"}, high_time, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_bar"}, bar, 0);
    chk({tag, "_no_signal"}, no_signal, 1);
  endtask

  // Monitor: pops the scoreboard on every valid, otherwise outputs must hold.
  always @(negedge clk) begin
    if (rst_n) begin
      while (sbq.size() > 0 && sbq[0].t < cyc) begin
        checks++;
        failures++;
        $display("FAIL missed_valid: expected at cycle %0d (now %0d)", sbq[0].t, cyc);
        void'(sbq.pop_front());
      end
      if (valid) begin
        chk("valid_expected", sbq.size() > 0, 1);
        if (sbq.size() > 0) begin
          exp_t e;
          e = sbq.pop_front();
          chk("valid_time", cyc, e.t);
          chk("period", period, e.p);
          chk("high_time", high_time, e.h);
          chk("duty", duty, e.d);
          chk("no_signal", no_signal, e.ns);
          chk("bar", bar, bar_ref(e.d));
          cur = e;
        end
      end else begin
        logic [64:0] act_v, exp_v;
        act_v = {duty, period, high_time, no_signal, bar};
        exp_v = {8'(cur.d), CW'(cur.p), CW'(cur.h), cur.ns, bar_ref(cur.d)};
        checks++;
        if (act_v !== exp_v) begin
          failures++;
          $display("FAIL hold: got %h expected %h (cycle %0d)", act_v, exp_v, cyc);
        end
      end
    end
  end

  initial begin
    int p, h;
    cur = reset_rec();
    rst_n = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values("reset");
    rst_n = 1'b1;
    model_reset();

    // Idle input well past the timeout: still in IDLE, nothing reported.
    repeat (TO + 1000) drive_bit(1'b0);
    chk("idle_no_signal", no_signal, 1);
    chk("idle_duty", duty, 0);
    chk("idle_bar", bar, 0);

    // 25% PWM lock, then input stuck high until loss-of-signal.
    drive_pwm(12000, 3000, 2);
    repeat (TO + 50) drive_bit(1'b1);
    chk("stuck_high_duty", duty, 255);
    chk("stuck_high_bar", bar, 8'hFF);
    chk("stuck_high_no_signal", no_signal, 1);

    // Resume at 50%.
    drive_pwm(200, 100, 4);
    chk("resume_duty", duty, 128);
    chk("resume_no_signal", no_signal, 0);
    chk("resume_period", period, 200);

    // Period shorter than the divide: every second period is dropped.
    drive_pwm(6, 3, 12);
    chk("short_period", period, 6);
    chk("short_duty", duty, 128);

    // 1000/500 with a one-cycle glitch in the low phase.
    repeat (4) begin
      repeat (500) drive_bit(1'b1);
      repeat (250) drive_bit(1'b0);
      drive_bit(1'b1);
      repeat (249) drive_bit(1'b0);
    end
`ifdef PWM_CAPTURE_DEGLITCH_EN
    chk("glitch_duty", duty, 128);
`else
    chk("glitch_duty", duty, (500 * 256) / 750);
`endif

    // Random frequencies and duties.
    for (int r = 0; r < 6; r++) begin
      p = $urandom_range(400, 12);
      h = $urandom_range(p - 1, 1);
      drive_pwm(p, h, 3);
    end

    // Reset four cycles after an accepted edge, i.e. mid-divide.
    drive_pwm(100, 40, 2);
    repeat (6) drive_bit(1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    pwm_in = 1'b0;
    cur = reset_rec();
    #1;
    chk_reset_values("mid_divide_reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    drive_pwm(100, 40, 3);
    repeat (40) drive_bit(1'b0);
    chk("after_reset_duty", duty, duty_ref(40, 100));

    chk("scoreboard_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
